dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-requester arbiter and sequencer for the single-port data memory (DynamicMemory: CLK, WE, funct3, ADDRESS, WRITE_DATA, combinational READ_DATA).
- Port 0 is the CPU load/store unit; port 1 is the loader/debug port that fills or inspects data memory.
- Grants one access at a time, drives the memory interface for exactly one cycle, and returns captured read data with a one-cycle ACK.
- Rejects misaligned or out-of-range accesses with ERR instead of touching memory.

Parameters:
ADDR_WIDTH, 10, byte-address width of data memory (1024 bytes); addresses at or above 2^ADDR_WIDTH are out of range.
ROUND_ROBIN, 1, 1 = fair alternation between ports; 0 = fixed priority, port 0 always wins.

Ports:
CLK  in  1  system clock, all state updates on rising edge
RST  in  1  synchronous reset, active-high
REQ0  in  1  port 0 request; held until ACK0
WE0  in  1  port 0 store (1) / load (0)
FUNCT3_0  in  3  port 0 RISC-V funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu)
ADDR0  in  32  port 0 byte address
WDATA0  in  32  port 0 store data
ACK0  out  1  port 0 completion pulse, one cycle
RDATA0  out  32  port 0 load data, valid while ACK0=1
ERR0  out  1  port 0 access rejected, valid while ACK0=1
REQ1, WE1, FUNCT3_1, ADDR1, WDATA1, ACK1, RDATA1, ERR1: same as port 0, for port 1
MEM_WE  out  1  to memory WE
MEM_FUNCT3  out  3  to memory funct3
MEM_ADDRESS  out  32  to memory ADDRESS
MEM_WRITE_DATA  out  32  to memory WRITE_DATA
MEM_READ_DATA  in  32  from memory READ_DATA (combinational)

Behaviour:
- Reset values: state IDLE, all ACKx/ERRx/MEM_WE = 0, RDATAx = 0, MEM_* buses = 0, last-grant pointer = 1 (port 0 wins first tie).
- FSM states: IDLE, ACCESS, RESP. All outputs are registered.
- IDLE: if any REQ is high at an edge, pick the winner, latch its WE/FUNCT3/ADDR/WDATA onto the MEM_* registers, and go to ACCESS.
- Round-robin tie-break: the port not granted last. Fixed mode: port 0. A lone requester always wins.
- Legality check, performed in IDLE on the winner's latched request:
  - FUNCT3 010 with ADDR[1:0] != 0 is illegal.
  - FUNCT3 001 or 101 with ADDR[0] != 0 is illegal.
  - ADDR >= 2^ADDR_WIDTH is illegal.
  - funct3 011, 110 or 111 is illegal.
  - Illegal accesses still pass through ACCESS, but with MEM_WE forced to 0 and a sticky err flag set.
- ACCESS lasts exactly one cycle.
  - MEM_WE = winner's WE (when legal). A store commits in memory at the edge that ends ACCESS.
  - At that same edge, MEM_READ_DATA is captured into the winner's RDATA (forced to 0 if illegal or a store), and the FSM moves to RESP.
- RESP lasts exactly one cycle.
  - Winner's ACK = 1 and ERR = err flag. The other port's ACK and ERR stay 0.
  - MEM_WE = 0.
  - Update the last-grant pointer, then go to IDLE.
- Latency: REQ sampled at edge k; ACCESS during cycle k..k+1; ACK high during cycle k+1..k+2. Peak throughput is one access per 3 cycles.
- RDATAx holds its value until that port's next completion.
- Requester protocol:
  - The requester must hold all request fields stable while REQ is high.
  - The requester must drop REQ on the edge where it sees ACK.
  - REQ still high in IDLE after RESP is treated as a new request.
- A REQ dropped before grant is simply not served. A REQ dropped after grant does not cancel the access; ACK still pulses.
- Both REQ high continuously, round-robin mode: grants alternate 0,1,0,1...
- Reset mid-operation: the FSM returns to IDLE and any pending ACK is lost.
  - A store whose ACCESS cycle coincides with the RST edge still commits, because the memory has no reset.
  - MEM_WE = 0 from the next cycle.
- MEM_FUNCT3 passes through unchanged; sign/zero extension is done by the memory.

Decomposition:
- Shared package/include `dmem_defs`: funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU), FSM state encodings, and an alignment-check function.
- One natural sub-module, `rr_arbiter2`: two-input round-robin/fixed priority picker with last-grant pointer, grant one-hot output, and an update strobe.

Test Plan:
- Port 0 only: store word, ADDR 0x0, WDATA 0xAABBCCDD, funct3 010; then load word from 0x0 -> ACK0 two cycles after REQ; RDATA0 = 0xAABBCCDD, ERR0 = 0; ACK1 never asserts.
- Port 1 byte store: 0xFF at ADDR 1, funct3 000; then port 0 load byte-unsigned at 1 -> RDATA0 = 0x000000FF; word at 0 reads 0xAABBFFDD.
- Both REQ held high for 4 accesses each (ROUND_ROBIN=1) -> grant order 0,1,0,1,...; exactly one ACK per RESP; MEM_WE never high outside ACCESS. With ROUND_ROBIN=0, port 0 gets all grants while REQ0 is held.
- Misaligned accesses:
  - Word store at ADDR 0x6 -> ACK with ERR = 1, RDATA = 0, and the word at 0x4 unchanged (verified by a following load).
  - Halfword load at 0x3 -> ERR = 1.
  - ADDR 0x400 -> ERR = 1.
- RST asserted during RESP of a port 0 load -> ACK0 not seen after reset; next cycle state IDLE, all outputs 0; a subsequent store/load of 0x11223344 at ADDR 4 works.
- REQ0 held high after ACK0 -> treated as a second access; ACK0 pulses again 3 cycles after the first ACK.

Source files
------------

// File: rtl/dmem_defs.sv
// Shared definitions for the data-memory arbiter: funct3 codes,
// sequencer states and the access-size alignment check.
package dmem_defs;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    // True when funct3 is a supported size and the address is naturally aligned.
    function automatic logic f3_access_ok(input logic [2:0] f3,
                                          input logic [1:0] lsb);
        case (f3)
            F3_B, F3_BU: return 1'b1;
            F3_H, F3_HU: return ~lsb[0];
            F3_W:        return lsb == 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input picker: round-robin on ties (or fixed port-0 priority),
// with a last-grant pointer updated by a strobe.
module rr_arbiter2 #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    input  logic       upd_idx_i,
    output logic [1:0] gnt_o
);

    logic last_q;

    // Reset to "port 1 granted last" so port 0 wins the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else if (upd_i) begin
            last_q <= upd_idx_i;
        end
    end

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = ((ROUND_ROBIN != 0) && !last_q) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer for the single-port data memory:
// IDLE -> ACCESS (one memory cycle) -> RESP (one-cycle ACK).
module dmem_arbiter
    import dmem_defs::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int ROUND_ROBIN = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ0,
    input  logic        WE0,
    input  logic [2:0]  FUNCT3_0,
    input  logic [31:0] ADDR0,
    input  logic [31:0] WDATA0,
    output logic        ACK0,
    output logic [31:0] RDATA0,
    output logic        ERR0,
    input  logic        REQ1,
    input  logic        WE1,
    input  logic [2:0]  FUNCT3_1,
    input  logic [31:0] ADDR1,
    input  logic [31:0] WDATA1,
    output logic        ACK1,
    output logic [31:0] RDATA1,
    output logic        ERR1,
    output logic        MEM_WE,
    output logic [2:0]  MEM_FUNCT3,
    output logic [31:0] MEM_ADDRESS,
    output logic [31:0] MEM_WRITE_DATA,
    input  logic [31:0] MEM_READ_DATA
);

    state_t      state_q, state_d;
    logic        win_q, win_d;
    logic        err_q, err_d;
    logic        mem_we_q, mem_we_d;
    logic [2:0]  mem_f3_q, mem_f3_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        err0_q, err0_d;
    logic        err1_q, err1_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    logic [1:0]  gnt;
    logic        sel;
    logic        sel_we;
    logic [2:0]  sel_f3;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_ok;
    logic [31:0] rd_val;

    rr_arbiter2 #(
        .ROUND_ROBIN(ROUND_ROBIN)
    ) u_arb (
        .clk_i    (CLK),
        .rst_i    (RST),
        .req_i    ({REQ1, REQ0}),
        .upd_i    (state_q == S_RESP),
        .upd_idx_i(win_q),
        .gnt_o    (gnt)
    );

    assign sel       = gnt[1];
    assign sel_we    = sel ? WE1 : WE0;
    assign sel_f3    = sel ? FUNCT3_1 : FUNCT3_0;
    assign sel_addr  = sel ? ADDR1 : ADDR0;
    assign sel_wdata = sel ? WDATA1 : WDATA0;
    assign sel_ok    = f3_access_ok(sel_f3, sel_addr[1:0])
                     && (sel_addr[31:ADDR_WIDTH] == '0);

    // Rejected accesses and stores return zero read data.
    assign rd_val = (err_q || mem_we_q) ? 32'h0 : MEM_READ_DATA;

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        err_d       = err_q;
        mem_we_d    = 1'b0;
        mem_f3_d    = mem_f3_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        err0_d      = 1'b0;
        err1_d      = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        case (state_q)
            S_IDLE: begin
                if (|gnt) begin
                    win_d       = sel;
                    err_d       = ~sel_ok;
                    mem_we_d    = sel_we & sel_ok;
                    mem_f3_d    = sel_f3;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    state_d     = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (win_q) begin
                    ack1_d   = 1'b1;
                    err1_d   = err_q;
                    rdata1_d = rd_val;
                end else begin
                    ack0_d   = 1'b1;
                    err0_d   = err_q;
                    rdata0_d = rd_val;
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            win_q       <= 1'b0;
            err_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_f3_q    <= 3'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            rdata0_q    <= 32'h0;
            rdata1_q    <= 32'h0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            err_q       <= err_d;
            mem_we_q    <= mem_we_d;
            mem_f3_q    <= mem_f3_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            err0_q      <= err0_d;
            err1_q      <= err1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign ACK0           = ack0_q;
    assign ACK1           = ack1_q;
    assign ERR0           = err0_q;
    assign ERR1           = err1_q;
    assign RDATA0         = rdata0_q;
    assign RDATA1         = rdata1_q;
    assign MEM_WE         = mem_we_q;
    assign MEM_FUNCT3     = mem_f3_q;
    assign MEM_ADDRESS    = mem_addr_q;
    assign MEM_WRITE_DATA = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural data memory, reference byte array
// and per-port scoreboards of {err, rdata} expected at each ACK.
module tb_dmem_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req   [2];
    logic        we    [2];
    logic [2:0]  f3    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        ack   [2];
    logic        err   [2];
    logic [31:0] rdata [2];
    logic        MEM_WE;
    logic [2:0]  MEM_FUNCT3;
    logic [31:0] MEM_ADDRESS, MEM_WRITE_DATA, MEM_READ_DATA;

    logic        fp_req0 = 1'b0, fp_req1 = 1'b0;
    logic        fp_ack0, fp_ack1, fp_err0, fp_err1, fp_we;
    logic [31:0] fp_rd0, fp_rd1, fp_ma, fp_mwd;
    logic [2:0]  fp_mf3;

    int nvec = 0;
    int nerr = 0;
    logic [32:0] q0[$];
    logic [32:0] q1[$];
    int glog[$];
    logic we_prev = 1'b0;

    logic [7:0] mem     [1024];
    logic [7:0] ref_mem [1024];

    always #5 CLK = ~CLK;

    dmem_arbiter #(.ADDR_WIDTH(10), .ROUND_ROBIN(1)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(req[0]), .WE0(we[0]), .FUNCT3_0(f3[0]), .ADDR0(addr[0]),
        .WDATA0(wdata[0]), .ACK0(ack[0]), .RDATA0(rdata[0]), .ERR0(err[0]),
        .REQ1(req[1]), .WE1(we[1]), .FUNCT3_1(f3[1]), .ADDR1(addr[1]),
        .WDATA1(wdata[1]), .ACK1(ack[1]), .RDATA1(rdata[1]), .ERR1(err[1]),
        .MEM_WE(MEM_WE), .MEM_FUNCT3(MEM_FUNCT3), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_WRITE_DATA(MEM_WRITE_DATA), .MEM_READ_DATA(MEM_READ_DATA)
    );

    dmem_arbiter #(.ADDR_WIDTH(10), .ROUND_ROBIN(0)) dut_fp (
        .CLK(CLK), .RST(RST),
        .REQ0(fp_req0), .WE0(1'b0), .FUNCT3_0(3'b010), .ADDR0(32'h0),
        .WDATA0(32'h0), .ACK0(fp_ack0), .RDATA0(fp_rd0), .ERR0(fp_err0),
        .REQ1(fp_req1), .WE1(1'b0), .FUNCT3_1(3'b010), .ADDR1(32'h4),
        .WDATA1(32'h0), .ACK1(fp_ack1), .RDATA1(fp_rd1), .ERR1(fp_err1),
        .MEM_WE(fp_we), .MEM_FUNCT3(fp_mf3), .MEM_ADDRESS(fp_ma),
        .MEM_WRITE_DATA(fp_mwd), .MEM_READ_DATA(32'h0)
    );

    // Behavioural DynamicMemory: little-endian, combinational read.
    logic [9:0] ra;
    logic [7:0] b0, b1, b2, b3;
    assign ra = MEM_ADDRESS[9:0];
    assign b0 = mem[ra];
    assign b1 = mem[10'(ra + 10'd1)];
    assign b2 = mem[10'(ra + 10'd2)];
    assign b3 = mem[10'(ra + 10'd3)];
    always_comb begin
        case (MEM_FUNCT3)
            3'b000:  MEM_READ_DATA = {{24{b0[7]}}, b0};
            3'b001:  MEM_READ_DATA = {{16{b1[7]}}, b1, b0};
            3'b100:  MEM_READ_DATA = {24'h0, b0};
            3'b101:  MEM_READ_DATA = {16'h0, b1, b0};
            default: MEM_READ_DATA = {b3, b2, b1, b0};
        endcase
    end
    always @(posedge CLK) begin
        if (MEM_WE) begin
            mem[ra] <= MEM_WRITE_DATA[7:0];
            if (MEM_FUNCT3[1:0] != 2'b00)
                mem[10'(ra + 10'd1)] <= MEM_WRITE_DATA[15:8];
            if (MEM_FUNCT3[1:0] == 2'b10) begin
                mem[10'(ra + 10'd2)] <= MEM_WRITE_DATA[23:16];
                mem[10'(ra + 10'd3)] <= MEM_WRITE_DATA[31:24];
            end
        end
    end

    function automatic bit legal(input logic [2:0] f, input logic [31:0] a);
        if (a >= 32'h400) return 1'b0;
        case (f)
            3'b000, 3'b100: return 1'b1;
            3'b001, 3'b101: return a[0] == 1'b0;
            3'b010:         return a[1:0] == 2'b00;
            default:        return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_read(input logic [2:0] f,
                                             input logic [31:0] a);
        int i;
        logic [31:0] w;
        i = int'(a[9:0]);
        w = {ref_mem[(i+3)%1024], ref_mem[(i+2)%1024],
             ref_mem[(i+1)%1024], ref_mem[i]};
        case (f)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'h0, w[7:0]};
            3'b101:  return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    task automatic ref_write(input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] d);
        int i;
        i = int'(a[9:0]);
        ref_mem[i] = d[7:0];
        if (f[1:0] != 2'b00) ref_mem[i+1] = d[15:8];
        if (f[1:0] == 2'b10) begin
            ref_mem[i+2] = d[23:16];
            ref_mem[i+3] = d[31:24];
        end
    endtask

    // Compute expectation from the reference array and queue it.
    task automatic expect_push(input int p, input logic w, input logic [2:0] f,
                               input logic [31:0] a, input logic [31:0] d);
        logic ok;
        logic [31:0] rv;
        ok = legal(f, a);
        rv = (ok && !w) ? ref_read(f, a) : 32'h0;
        if (ok && w) ref_write(f, a, d);
        if (p == 0) q0.push_back({~ok, rv});
        else        q1.push_back({~ok, rv});
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge CLK) begin
        logic [32:0] e;
        if (MEM_WE) begin
            nvec++;
            if (we_prev || ack[0] || ack[1]) begin
                nerr++;
                $display("FAIL mem_we_window: we_prev=%0b ack0=%0b ack1=%0b, required 0",
                         we_prev, ack[0], ack[1]);
            end
        end
        we_prev = MEM_WE;
        for (int p = 0; p < 2; p++) begin
            if (ack[p]) begin
                nvec++;
                if ((p == 0 ? q0.size() : q1.size()) == 0) begin
                    nerr++;
                    $display("FAIL unexpected_ack%0d: ack=1, required 0", p);
                end else begin
                    e = (p == 0) ? q0.pop_front() : q1.pop_front();
                    glog.push_back(p);
                    nvec++;
                    if (rdata[p] !== e[31:0]) begin
                        nerr++;
                        $display("FAIL rdata%0d: got %h, required %h", p, rdata[p], e[31:0]);
                    end
                    nvec++;
                    if (err[p] !== e[32]) begin
                        nerr++;
                        $display("FAIL err%0d: got %0b, required %0b", p, err[p], e[32]);
                    end
                end
            end
        end
    end

    task automatic issue(input int p, input logic w, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat);
        expect_push(p, w, f, a, d);
        @(negedge CLK);
        we[p] = w; f3[p] = f; addr[p] = a; wdata[p] = d; req[p] = 1'b1;
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (!ack[p] && lat < 30);
        if (!ack[p]) begin
            nvec++; nerr++;
            $display("FAIL ack_timeout%0d: no ACK within 30 cycles", p);
        end
        @(posedge CLK);
        #1 req[p] = 1'b0;
    endtask

    task automatic check_zero(input string nm);
        nvec++;
        if ({ack[0], ack[1], err[0], err[1], MEM_WE, MEM_FUNCT3, rdata[0],
             rdata[1], MEM_ADDRESS, MEM_WRITE_DATA} !== '0) begin
            nerr++;
            $display("FAIL %s: ack=%b%b err=%b%b we=%b f3=%h rd0=%h rd1=%h ma=%h wd=%h, required all 0",
                     nm, ack[0], ack[1], err[0], err[1], MEM_WE, MEM_FUNCT3,
                     rdata[0], rdata[1], MEM_ADDRESS, MEM_WRITE_DATA);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check_zero("reset_state");
        RST = 1'b0;
    endtask

    task automatic test_rr_both();
        glog.delete();
        fork
            begin
                int l;
                for (int i = 0; i < 4; i++)
                    issue(0, 1'b1, 3'b010, 32'h100 + 32'(8*i), 32'hA0A0_0000 + 32'(i), l);
            end
            begin
                int l;
                for (int i = 0; i < 4; i++)
                    issue(1, 1'b1, 3'b010, 32'h200 + 32'(8*i), 32'hB1B1_0000 + 32'(i), l);
            end
        join
        nvec++;
        if (glog.size() != 8) begin
            nerr++;
            $display("FAIL rr_count: got %0d grants, required 8", glog.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                nvec++;
                if (glog[i] != i % 2) begin
                    nerr++;
                    $display("FAIL rr_order[%0d]: got port %0d, required %0d", i, glog[i], i % 2);
                end
            end
        end
        begin
            int l;
            issue(1, 1'b0, 3'b010, 32'h108, 32'h0, l);
            issue(0, 1'b0, 3'b010, 32'h218, 32'h0, l);
        end
    endtask

    task automatic test_port0_word();
        int l;
        issue(0, 1'b1, 3'b010, 32'h0, 32'hAABBCCDD, l);
        issue(0, 1'b0, 3'b010, 32'h0, 32'h0, l);
        nvec++;
        if (l != 2) begin
            nerr++;
            $display("FAIL load_latency: got %0d cycles, required 2", l);
        end
    endtask

    task automatic test_port1_byte();
        int l;
        issue(1, 1'b1, 3'b000, 32'h1, 32'h000000FF, l);
        nvec++;
        if (rdata[0] !== 32'hAABBCCDD) begin
            nerr++;
            $display("FAIL rdata0_hold: got %h, required aabbccdd", rdata[0]);
        end
        issue(0, 1'b0, 3'b100, 32'h1, 32'h0, l);
        nvec++;
        if (rdata[0] !== 32'h000000FF) begin
            nerr++;
            $display("FAIL lbu_value: got %h, required 000000ff", rdata[0]);
        end
        issue(0, 1'b0, 3'b010, 32'h0, 32'h0, l);
        nvec++;
        if (rdata[0] !== 32'hAABBFFDD) begin
            nerr++;
            $display("FAIL merged_word: got %h, required aabbffdd", rdata[0]);
        end
    endtask

    task automatic test_misaligned();
        int l;
        issue(0, 1'b1, 3'b010, 32'h4, 32'h55667788, l);
        issue(0, 1'b1, 3'b010, 32'h6, 32'hDEADBEEF, l);
        issue(0, 1'b0, 3'b010, 32'h4, 32'h0, l);
        issue(1, 1'b0, 3'b001, 32'h3, 32'h0, l);
        issue(1, 1'b0, 3'b010, 32'h400, 32'h0, l);
        issue(0, 1'b0, 3'b011, 32'h0, 32'h0, l);
        issue(1, 1'b0, 3'b101, 32'h6, 32'h0, l);
    endtask

    task automatic test_back_to_back();
        int n;
        expect_push(0, 1'b0, 3'b010, 32'h0, 32'h0);
        expect_push(0, 1'b0, 3'b010, 32'h0, 32'h0);
        @(negedge CLK);
        we[0] = 1'b0; f3[0] = 3'b010; addr[0] = 32'h0; req[0] = 1'b1;
        n = 0;
        do begin @(negedge CLK); n++; end while (!ack[0] && n < 30);
        n = 0;
        do begin @(negedge CLK); n++; end while (!ack[0] && n < 30);
        nvec++;
        if (n != 3) begin
            nerr++;
            $display("FAIL reack_gap: got %0d cycles, required 3", n);
        end
        @(posedge CLK);
        #1 req[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        int l;
        expect_push(0, 1'b0, 3'b010, 32'h0, 32'h0);
        @(negedge CLK);
        we[0] = 1'b0; f3[0] = 3'b010; addr[0] = 32'h0; req[0] = 1'b1;
        n = 0;
        do begin @(negedge CLK); n++; end while (!ack[0] && n < 30);
        RST = 1'b1; req[0] = 1'b0;
        @(negedge CLK);
        check_zero("reset_in_resp");
        RST = 1'b0;
        issue(0, 1'b1, 3'b010, 32'h4, 32'h11223344, l);
        issue(0, 1'b0, 3'b010, 32'h4, 32'h0, l);
        nvec++;
        if (rdata[0] !== 32'h11223344) begin
            nerr++;
            $display("FAIL post_reset_load: got %h, required 11223344", rdata[0]);
        end
        // Store whose ACCESS cycle ends on the reset edge still lands in memory.
        ref_write(3'b010, 32'h8, 32'hCAFEF00D);
        @(negedge CLK);
        we[0] = 1'b1; f3[0] = 3'b010; addr[0] = 32'h8; wdata[0] = 32'hCAFEF00D;
        req[0] = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b1; req[0] = 1'b0;
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check_zero("reset_in_access");
        repeat (3) @(negedge CLK);
        issue(1, 1'b0, 3'b010, 32'h8, 32'h0, l);
    endtask

    task automatic test_fixed_priority();
        int c0, c1;
        c0 = 0; c1 = 0;
        @(negedge CLK);
        fp_req0 = 1'b1; fp_req1 = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            if (fp_ack0) c0++;
            if (fp_ack1) c1++;
        end
        fp_req0 = 1'b0; fp_req1 = 1'b0;
        nvec++;
        if (c0 != 5 || c1 != 0) begin
            nerr++;
            $display("FAIL fixed_prio: ack0=%0d ack1=%0d, required 5 and 0", c0, c1);
        end
        repeat (4) @(negedge CLK);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 8'h0;
            ref_mem[i] = 8'h0;
        end
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; we[p] = 1'b0; f3[p] = 3'b0;
            addr[p] = 32'h0; wdata[p] = 32'h0;
        end
        test_reset();
        test_rr_both();
        test_port0_word();
        test_port1_byte();
        test_misaligned();
        test_back_to_back();
        test_reset_mid();
        test_fixed_priority();
        repeat (3) @(negedge CLK);
        nvec++;
        if (q0.size() != 0 || q1.size() != 0) begin
            nerr++;
            $display("FAIL drain: pending q0=%0d q1=%0d, required 0", q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
